yrv_mem_arb: RTL and testbench
==============================

YRV_MEM_ARB -- requirements
Module: yrv_mem_arb

Interface
REQ-001 Parameter AW, default 14, memory word-address width.
REQ-002 Parameter DW, default 32, data width; byte-enable width is DW/8.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cpu_req  input  1  CPU access request; held until cpu_ack.
REQ-006 cpu_we  input  1  CPU write (1) / read (0).
REQ-007 cpu_be  input  DW/8  CPU byte enables for writes.
REQ-008 cpu_addr  input  AW  CPU word address.
REQ-009 cpu_wdata  input  DW  CPU write data.
REQ-010 cpu_ack  output  1  one-cycle completion pulse to CPU.
REQ-011 ldr_req, ldr_we, ldr_be, ldr_addr, ldr_wdata  input  1/1/DW/8/AW/DW  loader (aux-UART boot loader) request set, same meaning as CPU set.
REQ-012 ldr_ack  output  1  one-cycle completion pulse to loader.
REQ-013 ldr_lock  input  1  loader exclusive ownership; CPU requests not granted while high.
REQ-014 rdata  output  DW  read data, valid only in the cycle the matching ack is high.
REQ-015 mem_en  output  1  memory access strobe, registered.
REQ-016 mem_wbe  output  DW/8  memory byte write enables, registered; all zero on reads.
REQ-017 mem_addr  output  AW  memory address, registered.
REQ-018 mem_wdata  output  DW  memory write data, registered.
REQ-019 mem_rdata  input  DW  synchronous-read memory data, valid one cycle after mem_en.
REQ-020 gnt_id  output  1  current/last owner (0=CPU, 1=loader), for debug.
REQ-021 busy  output  1  high in any state other than IDLE.

Function
REQ-022 FSM states SHALL be IDLE, ACCESS, RESP; ACCESS->RESP and RESP->IDLE unconditionally.
REQ-023 IDLE->ACCESS when an eligible request exists; eligible = ldr_req, or cpu_req with ldr_lock low.
REQ-024 Single eligible requester: granted. Both eligible: requester not equal to last_gnt wins (round robin).
REQ-025 At grant, winner's we/be/addr/wdata SHALL be latched into mem_* registers; mem_en high for exactly the ACCESS cycle; mem_wbe = be when we=1, else zero.
REQ-026 In RESP, winner's ack SHALL pulse for exactly one cycle; rdata = mem_rdata in that cycle, zero otherwise.
REQ-027 Latency: request sampled in IDLE at edge N -> mem_en high cycle N+1 -> ack high cycle N+2; one access per 3 cycles maximum.
REQ-028 Requester signals SHALL be sampled only in IDLE; changes during ACCESS/RESP have no effect on the access in flight.
REQ-029 A request withdrawn before grant SHALL be dropped without ack.
REQ-030 ldr_lock rising during a CPU access SHALL NOT abort it; CPU access completes and acks.
REQ-031 last_gnt SHALL update at grant; gnt_id = last_gnt.
REQ-032 Never both acks high in the same cycle; never ack without a preceding mem_en.

Reset
REQ-033 Reset asserted: state=IDLE, mem_en=0, mem_wbe=0, mem_addr=0, mem_wdata=0, cpu_ack=0, ldr_ack=0, rdata=0, busy=0, last_gnt=loader (so CPU wins first tie), gnt_id=1.
REQ-034 Reset mid-access SHALL deassert mem_en immediately (asynchronously); the in-flight access is abandoned with no ack.

Structure
REQ-035 Package yrv_arb_pkg SHALL hold the state enum (IDLE/ACCESS/RESP), requester-id enum (CPU=0, LDR=1), and default AW/DW constants.
REQ-036 No sub-module; round-robin pick and FSM reside in yrv_mem_arb.

Verification
REQ-037 CPU read addr 0x0010, mem returns 0xDEADBEEF -> mem_en cycle N+1 with mem_wbe=0, cpu_ack and rdata=0xDEADBEEF cycle N+2.
REQ-038 Both request same cycle after reset -> CPU granted first (gnt_id=0), loader granted next IDLE, then CPU again if both still request.
REQ-039 ldr_lock=1, CPU and loader write continuously -> only ldr_ack pulses; cpu_ack stays 0 until ldr_lock=0.
REQ-040 Loader write addr 0x3FFF, be=0x3, data 0x12345678 -> mem_wbe=0x3, mem_addr=0x3FFF, mem_wdata=0x12345678, ldr_ack cycle N+2.
REQ-041 Reset asserted during ACCESS -> mem_en falls same cycle, no ack, after release first tie goes to CPU.
REQ-042 cpu_req pulsed one cycle while arbiter in RESP -> no grant, no ack.

Source files
------------

// File: rtl/yrv_arb_pkg.sv
// Shared types and defaults for the YRV memory arbiter: FSM states,
// requester ids and default address/data widths.
package yrv_arb_pkg;

    localparam int ARB_AW = 14;
    localparam int ARB_DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        CPU = 1'b0,
        LDR = 1'b1
    } req_id_t;

endpackage

// File: rtl/yrv_mem_arb.sv
// Two-requester (CPU / boot loader) arbiter in front of a synchronous-read
// memory: round-robin on ties, loader lock, one access per three cycles.
module yrv_mem_arb
    import yrv_arb_pkg::*;
#(
    parameter int AW = ARB_AW,
    parameter int DW = ARB_DW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cpu_req,
    input  logic            cpu_we,
    input  logic [DW/8-1:0] cpu_be,
    input  logic [AW-1:0]   cpu_addr,
    input  logic [DW-1:0]   cpu_wdata,
    output logic            cpu_ack,
    input  logic            ldr_req,
    input  logic            ldr_we,
    input  logic [DW/8-1:0] ldr_be,
    input  logic [AW-1:0]   ldr_addr,
    input  logic [DW-1:0]   ldr_wdata,
    output logic            ldr_ack,
    input  logic            ldr_lock,
    output logic [DW-1:0]   rdata,
    output logic            mem_en,
    output logic [DW/8-1:0] mem_wbe,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    output logic            gnt_id,
    output logic            busy,
    output arb_state_t      state_dbg
);

    // Handshake: a requester raises *_req with its we/be/addr/wdata and holds
    // them until its *_ack; ack is a single-cycle completion pulse, and for
    // reads rdata is valid only in that ack cycle. Inputs are sampled in IDLE only.

    arb_state_t        state;
    arb_state_t        state_nxt;
    req_id_t           last_gnt;
    req_id_t           winner;
    logic              grant;
    logic              cpu_elig;
    logic              ldr_elig;
    logic              sel_we;
    logic [DW/8-1:0]   sel_be;
    logic [AW-1:0]     sel_addr;
    logic [DW-1:0]     sel_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        winner    = CPU;
        cpu_elig  = cpu_req & ~ldr_lock;
        ldr_elig  = ldr_req;
        case (state)
            IDLE: begin
                if (cpu_elig || ldr_elig) begin
                    grant     = 1'b1;
                    state_nxt = ACCESS;
                    // On a tie the side that did not own the last grant wins.
                    if (cpu_elig && ldr_elig) begin
                        winner = (last_gnt == CPU) ? LDR : CPU;
                    end else begin
                        winner = ldr_elig ? LDR : CPU;
                    end
                end
            end
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sel_we    = (winner == LDR) ? ldr_we    : cpu_we;
        sel_be    = (winner == LDR) ? ldr_be    : cpu_be;
        sel_addr  = (winner == LDR) ? ldr_addr  : cpu_addr;
        sel_wdata = (winner == LDR) ? ldr_wdata : cpu_wdata;
    end

    // mem_en/mem_wbe are high only in the ACCESS cycle; address/data hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt  <= LDR;
            mem_en    <= 1'b0;
            mem_wbe   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en  <= grant;
            mem_wbe <= '0;
            if (grant) begin
                last_gnt  <= winner;
                mem_wbe   <= sel_we ? sel_be : '0;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
        end
    end

    assign cpu_ack   = (state == RESP) && (last_gnt == CPU);
    assign ldr_ack   = (state == RESP) && (last_gnt == LDR);
    assign rdata     = (state == RESP) ? mem_rdata : '0;
    assign busy      = (state != IDLE);
    assign gnt_id    = last_gnt;
    assign state_dbg = state;

endmodule

// File: tb/tb_yrv_mem_arb.sv
// Directed bench for yrv_mem_arb: a behavioural synchronous-read memory,
// an ack scoreboard fed at stimulus time, and immediate-assertion checks.
module tb_yrv_mem_arb;
    import yrv_arb_pkg::*;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int W  = 1 + DW;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            cpu_req = 1'b0;
    logic            cpu_we = 1'b0;
    logic [BW-1:0]   cpu_be = '0;
    logic [AW-1:0]   cpu_addr = '0;
    logic [DW-1:0]   cpu_wdata = '0;
    logic            cpu_ack;
    logic            ldr_req = 1'b0;
    logic            ldr_we = 1'b0;
    logic [BW-1:0]   ldr_be = '0;
    logic [AW-1:0]   ldr_addr = '0;
    logic [DW-1:0]   ldr_wdata = '0;
    logic            ldr_ack;
    logic            ldr_lock = 1'b0;
    logic [DW-1:0]   rdata;
    logic            mem_en;
    logic [BW-1:0]   mem_wbe;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata = '0;
    logic            gnt_id;
    logic            busy;
    arb_state_t      state_dbg;

    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_q[$];
    logic en_d = 1'b0;

    yrv_mem_arb #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_be(ldr_be),
        .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack),
        .ldr_lock(ldr_lock), .rdata(rdata),
        .mem_en(mem_en), .mem_wbe(mem_wbe), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .gnt_id(gnt_id), .busy(busy), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        if (a == 14'h0010) return 32'hDEADBEEF;
        return {18'h15A5A, a};
    endfunction

    // memory model: data for the address strobed in one cycle appears in the next
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem_fn(mem_addr);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every ack is matched against the next queued {owner, rdata}
    always @(negedge clk) begin
        if (!reset) begin
            chk("both_acks", 64'(cpu_ack & ldr_ack), 64'(0));
            if (cpu_ack || ldr_ack) begin
                chk("ack_after_en", 64'(en_d), 64'(1));
                chk("ack_expected", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    chk("ack_owner", 64'(ldr_ack), 64'(e[W-1]));
                    chk("ack_rdata", 64'(rdata), 64'(e[DW-1:0]));
                end
            end else begin
                chk("rdata_idle", 64'(rdata), 64'(0));
            end
        end
        en_d = mem_en;
    end

    // driver: one access from one requester, checked at fixed latency.
    // Entered and left one delta after a rising edge with the arbiter in IDLE.
    task automatic run_one(input logic who, input logic we, input logic [BW-1:0] be,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input bit raise_lock, input bit pulse_cpu);
        if (who) begin
            ldr_req = 1'b1; ldr_we = we; ldr_be = be; ldr_addr = addr; ldr_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wd;
        end
        exp_q.push_back({who, mem_fn(addr)});
        @(posedge clk);
        @(negedge clk);
        chk("acc_en", 64'(mem_en), 64'(1));
        chk("acc_wbe", 64'(mem_wbe), we ? 64'(be) : 64'(0));
        chk("acc_addr", 64'(mem_addr), 64'(addr));
        if (we) chk("acc_wdata", 64'(mem_wdata), 64'(wd));
        chk("acc_gnt", 64'(gnt_id), 64'(who));
        chk("acc_state", 64'(state_dbg), 64'(ACCESS));
        if (raise_lock) ldr_lock = 1'b1;
        if (who) ldr_req = 1'b0; else cpu_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("resp_ack", 64'(who ? ldr_ack : cpu_ack), 64'(1));
        chk("resp_other", 64'(who ? cpu_ack : ldr_ack), 64'(0));
        chk("resp_en", 64'(mem_en), 64'(0));
        chk("resp_busy", 64'(busy), 64'(1));
        if (pulse_cpu) cpu_req = 1'b1;
        @(posedge clk);
        #1;
        if (pulse_cpu) cpu_req = 1'b0;
    endtask

    // one round with both requesters held: expect 'who' to own it
    task automatic tie_round(input logic who);
        exp_q.push_back({who, mem_fn(who ? ldr_addr : cpu_addr)});
        @(posedge clk);
        @(negedge clk);
        chk("tie_gnt", 64'(gnt_id), 64'(who));
        chk("tie_en", 64'(mem_en), 64'(1));
        @(posedge clk);
        @(negedge clk);
        chk("tie_ack", 64'(who ? ldr_ack : cpu_ack), 64'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset values
        @(negedge clk);
        chk("rst_en", 64'(mem_en), 64'(0));
        chk("rst_wbe", 64'(mem_wbe), 64'(0));
        chk("rst_addr", 64'(mem_addr), 64'(0));
        chk("rst_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_acks", 64'({cpu_ack, ldr_ack}), 64'(0));
        chk("rst_rdata", 64'(rdata), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_gnt", 64'(gnt_id), 64'(1));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // simultaneous requests: CPU, loader, CPU
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0020;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 14'h0030;
        tie_round(1'b0);
        tie_round(1'b1);
        tie_round(1'b0);
        cpu_req = 1'b0; ldr_req = 1'b0;

        // CPU read of 0x0010
        run_one(1'b0, 1'b0, 4'hF, 14'h0010, 32'h0, 1'b0, 1'b0);

        // loader write at top of memory
        run_one(1'b1, 1'b1, 4'h3, 14'h3FFF, 32'h12345678, 1'b0, 1'b0);

        // loader lock: CPU keeps asking but only the loader is served
        ldr_lock = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF; cpu_addr = 14'h0100; cpu_wdata = 32'hCAFE0001;
        for (int i = 0; i < 3; i++)
            run_one(1'b1, 1'b1, 4'hC, 14'(14'h0200 + i), 32'h0BAD0000 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("lock_idle", 64'(busy), 64'(0));
            chk("lock_cpu_ack", 64'(cpu_ack), 64'(0));
        end
        @(posedge clk);
        #1;
        ldr_lock = 1'b0;
        run_one(1'b0, 1'b1, 4'hF, 14'h0100, 32'hCAFE0001, 1'b0, 1'b0);

        // lock raised mid CPU access does not abort it
        run_one(1'b0, 1'b0, 4'h0, 14'h0044, 32'h0, 1'b1, 1'b0);
        ldr_lock = 1'b0;

        // CPU pulse during RESP is never granted
        run_one(1'b1, 1'b0, 4'h0, 14'h0055, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("pulse_idle", 64'(busy), 64'(0));
            chk("pulse_no_en", 64'(mem_en), 64'(0));
        end
        @(posedge clk);
        #1;

        // reset during ACCESS
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF; cpu_addr = 14'h0077; cpu_wdata = 32'h77777777;
        @(posedge clk);
        @(negedge clk);
        chk("mid_en", 64'(mem_en), 64'(1));
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_en", 64'(mem_en), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_gnt", 64'(gnt_id), 64'(1));
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("mid_rst_acks", 64'({cpu_ack, ldr_ack}), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0066;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 14'h0067;
        tie_round(1'b0);
        cpu_req = 1'b0; ldr_req = 1'b0;
        @(posedge clk);
        #1;

        // a few random single accesses
        for (int i = 0; i < 6; i++) begin
            logic who, we;
            who = 1'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            run_one(who, we, 4'($urandom_range(1, 15)), 14'($urandom_range(0, 16383)),
                    $urandom, 1'b0, 1'b0);
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
